// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM state, owner encoding and
// the beat counter width helper.
package cache_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // A single-beat burst still needs a 1-bit counter to compare against.
    function automatic int beat_cnt_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input combinational picker for the icache/dcache refill paths.
// Define CACHE_MEM_ARB_DATA_PRIO_EN to give the dcache fixed priority.
module rr_arb2
    import cache_mem_arb_pkg::*;
(
    input  logic   i_valid_i,
    input  logic   d_valid_i,
    input  owner_t last_owner_i,
    output owner_t winner_o
);

    always_comb begin
        winner_o = OWN_I;
`ifdef CACHE_MEM_ARB_DATA_PRIO_EN
        if (d_valid_i) begin
            winner_o = OWN_D;
        end
`else
        // On a tie the requester that did not own the last burst wins.
        if (d_valid_i && (!i_valid_i || last_owner_i == OWN_I)) begin
            winner_o = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory request port between icache refills and dcache
// refill/writeback bursts. Grant policy lives in rr_arb2 (CACHE_MEM_ARB_DATA_PRIO_EN).
//
// state | meaning
// IDLE  | no burst; picks a winner and latches owner/rnw/addr
// REQ   | mem_req_valid up, waiting for mem_req_ready
// RDATA | read beats pass straight from memory to the owner
// WDATA | dcache write beats pass straight to memory
module cache_mem_arbiter
    import cache_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rdata_valid,
    input  logic              d_req_valid,
    input  logic              d_req_rnw,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wdata_ready,
    output logic              d_rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req_valid,
    output logic              mem_req_rnw,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              busy,
    output logic              proto_err
);

    localparam int BEAT_W = beat_cnt_w(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t              state_q;
    owner_t              owner_q;
    logic                rnw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic                proto_err_q;
    owner_t              grant;

    rr_arb2 u_arb (
        .i_valid_i    (i_req_valid),
        .d_valid_i    (d_req_valid),
        .last_owner_i (owner_q),
        .winner_o     (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            // Stray beats or accepts are flagged and otherwise ignored.
            if ((mem_rdata_valid && state_q != RDATA) ||
                (mem_req_ready && state_q != REQ)) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_req_valid || d_req_valid) begin
                        owner_q <= grant;
                        rnw_q   <= (grant == OWN_I) ? 1'b1 : d_req_rnw;
                        addr_q  <= (grant == OWN_I) ? i_req_addr : d_req_addr;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        beat_cnt_q <= '0;
                        state_q    <= rnw_q ? RDATA : WDATA;
                    end
                end
                RDATA: begin
                    if (mem_rdata_valid) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                WDATA: begin
                    if (mem_wdata_ready) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign proto_err       = proto_err_q;
    assign mem_req_valid   = (state_q == REQ);
    assign mem_req_rnw     = rnw_q;
    assign mem_req_addr    = addr_q;
    assign i_req_ready     = (state_q == REQ) && mem_req_ready && (owner_q == OWN_I);
    assign d_req_ready     = (state_q == REQ) && mem_req_ready && (owner_q == OWN_D);
    assign rdata           = (state_q == RDATA) ? mem_rdata : '0;
    assign i_rdata_valid   = (state_q == RDATA) && mem_rdata_valid && (owner_q == OWN_I);
    assign d_rdata_valid   = (state_q == RDATA) && mem_rdata_valid && (owner_q == OWN_D);
    assign mem_wdata       = (state_q == WDATA) ? d_wdata : '0;
    assign mem_wdata_valid = (state_q == WDATA);
    assign d_wdata_ready   = (state_q == WDATA) && mem_wdata_ready;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (default parameters).
module tb_cache_mem_arbiter;

    localparam logic [31:0] I_ADDR  = 32'h1000_0040;
    localparam logic [31:0] D_ADDR  = 32'h3000_0000;
    localparam logic [31:0] W_ADDR  = 32'h2000_0100;
`ifdef CACHE_MEM_ARB_DATA_PRIO_EN
    localparam logic [2:0]  ALT_I   = 3'b000;
    localparam logic        TIE_I   = 1'b0;
`else
    localparam logic [2:0]  ALT_I   = 3'b101;
    localparam logic        TIE_I   = 1'b1;
`endif

    logic         clk;
    logic         rst;
    logic         i_req_valid;
    logic [31:0]  i_req_addr;
    logic         i_req_ready;
    logic         i_rdata_valid;
    logic         d_req_valid;
    logic         d_req_rnw;
    logic [31:0]  d_req_addr;
    logic         d_req_ready;
    logic [127:0] d_wdata;
    logic         d_wdata_ready;
    logic         d_rdata_valid;
    logic [127:0] rdata;
    logic         mem_req_valid;
    logic         mem_req_rnw;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic [127:0] mem_wdata;
    logic         mem_wdata_valid;
    logic         mem_wdata_ready;
    logic [127:0] mem_rdata;
    logic         mem_rdata_valid;
    logic         busy;
    logic         proto_err;

    int tests = 0;
    int fails = 0;

    cache_mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .i_req_addr      (i_req_addr),
        .i_req_ready     (i_req_ready),
        .i_rdata_valid   (i_rdata_valid),
        .d_req_valid     (d_req_valid),
        .d_req_rnw       (d_req_rnw),
        .d_req_addr      (d_req_addr),
        .d_req_ready     (d_req_ready),
        .d_wdata         (d_wdata),
        .d_wdata_ready   (d_wdata_ready),
        .d_rdata_valid   (d_rdata_valid),
        .rdata           (rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rnw     (mem_req_rnw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_wdata       (mem_wdata),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .busy            (busy),
        .proto_err       (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serves one read burst: waits for REQ, accepts after `delay` REQ cycles,
    // returns four beats (with one idle gap before the third) and checks routing.
    task automatic serve_read(input string tag, input logic [31:0] exp_addr, input logic exp_i,
                              input int delay, input logic drop, input logic [127:0] base,
                              output int idle_n);
        int n;
        n = 0;
        @(negedge clk);
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        idle_n = n;
        chk({tag, ".wait"}, 128'(n < 20), 128'd1);
        chk({tag, ".addr"}, 128'(mem_req_addr), 128'(exp_addr));
        chk({tag, ".rnw"}, 128'(mem_req_rnw), 128'd1);
        for (int k = 0; k < delay; k++) begin
            chk({tag, ".rdy_early"}, 128'({i_req_ready, d_req_ready}), 128'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        #1;
        chk({tag, ".i_ready"}, 128'(i_req_ready), 128'(exp_i));
        chk({tag, ".d_ready"}, 128'(d_req_ready), 128'(!exp_i));
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        if (drop) begin
            if (exp_i) i_req_valid = 1'b0;
            else d_req_valid = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                @(negedge clk);
                chk({tag, ".gap_valid"}, 128'({i_rdata_valid, d_rdata_valid}), 128'd0);
                chk({tag, ".gap_busy"}, 128'(busy), 128'd1);
                @(posedge clk);
                #1;
            end
            mem_rdata = base + 128'(b);
            mem_rdata_valid = 1'b1;
            @(negedge clk);
            chk({tag, ".i_rvalid"}, 128'(i_rdata_valid), 128'(exp_i));
            chk({tag, ".d_rvalid"}, 128'(d_rdata_valid), 128'(!exp_i));
            chk({tag, ".rdata"}, rdata, base + 128'(b));
            @(posedge clk);
            #1;
            mem_rdata_valid = 1'b0;
        end
        chk({tag, ".busy_end"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs;
        logic [2:0] alt;
        logic [127:0] wbase;
        alt = ALT_I;
        wbase = 128'hCAFE_0000_0000_0000_0000_0000_0000_0100;
        rst = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr = I_ADDR;
        d_req_valid = 1'b0;
        d_req_rnw = 1'b1;
        d_req_addr = D_ADDR;
        d_wdata = '0;
        mem_req_ready = 1'b0;
        mem_wdata_ready = 1'b0;
        mem_rdata = 128'hDEAD_BEEF;
        mem_rdata_valid = 1'b0;

        // reset state
        #3;
        chk("rst.busy", 128'(busy), 128'd0);
        chk("rst.mem_req_valid", 128'(mem_req_valid), 128'd0);
        chk("rst.addr", 128'(mem_req_addr), 128'd0);
        chk("rst.rdata", rdata, 128'd0);
        chk("rst.ready", 128'({i_req_ready, d_req_ready, d_wdata_ready, mem_wdata_valid}), 128'd0);
        chk("rst.proto_err", 128'(proto_err), 128'd0);
        i_req_valid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // both requesters held for three bursts
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_req_rnw = 1'b1;
        for (int g = 0; g < 3; g++) begin
            serve_read($sformatf("alt%0d", g), alt[g] ? I_ADDR : D_ADDR, alt[g], 0, 1'b0,
                       128'h0A00 + 128'(g * 16), n);
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;

        // back-to-back d read then i read
        @(posedge clk);
        #1;
        i_req_addr = 32'h4000_0000;
        d_req_addr = D_ADDR;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        serve_read("b2b_d", D_ADDR, 1'b0, 0, 1'b1, 128'h0B00, n);
        serve_read("b2b_i", 32'h4000_0000, 1'b1, 0, 1'b1, 128'h0C00, n);
        chk("b2b.bubble", 128'(n), 128'd1);

        // single icache read with two-cycle accept delay
        i_req_addr = I_ADDR;
        i_req_valid = 1'b1;
        serve_read("iread", I_ADDR, 1'b1, 2, 1'b1,
                   128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6900, n);

        // dcache write-back with toggling write ready
        d_req_rnw = 1'b0;
        d_req_addr = W_ADDR;
        d_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr.wait", 128'(n < 20), 128'd1);
        chk("wr.addr", 128'(mem_req_addr), 128'(W_ADDR));
        chk("wr.rnw_req", 128'(mem_req_rnw), 128'd0);
        mem_req_ready = 1'b1;
        #1;
        chk("wr.d_ready", 128'({i_req_ready, d_req_ready}), 128'b01);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        d_req_valid = 1'b0;
        hs = 0;
        for (int c = 0; c < 7; c++) begin
            mem_wdata_ready = (c % 2 == 0);
            d_wdata = wbase + 128'(hs);
            @(negedge clk);
            chk("wr.wvalid", 128'(mem_wdata_valid), 128'd1);
            chk("wr.rnw", 128'(mem_req_rnw), 128'd0);
            chk("wr.wready", 128'(d_wdata_ready), 128'(c % 2 == 0));
            if (c % 2 == 0) chk("wr.wdata", mem_wdata, wbase + 128'(hs));
            if (d_wdata_ready === 1'b1) hs++;
            @(posedge clk);
            #1;
        end
        mem_wdata_ready = 1'b0;
        chk("wr.handshakes", 128'(hs), 128'd4);
        chk("wr.busy_end", 128'(busy), 128'd0);
        chk("wr.proto_clean", 128'(proto_err), 128'd0);

        // stray read beat while idle
        mem_rdata = 128'h5555;
        mem_rdata_valid = 1'b1;
        @(negedge clk);
        chk("stray.rvalid", 128'({i_rdata_valid, d_rdata_valid}), 128'd0);
        chk("stray.proto_pre", 128'(proto_err), 128'd0);
        @(posedge clk);
        #1;
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("stray.proto", 128'(proto_err), 128'd1);
        chk("stray.busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stray.sticky", 128'(proto_err), 128'd1);
        @(posedge clk);
        #1;

        // reset in the middle of a read burst
        i_req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mrst.wait", 128'(n < 20), 128'd1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        i_req_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rdata = 128'h7700 + 128'(b);
            mem_rdata_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        mem_rdata = 128'h7702;
        #2;
        rst = 1'b0;
        #1;
        chk("mrst.busy", 128'(busy), 128'd0);
        chk("mrst.rvalid", 128'({i_rdata_valid, d_rdata_valid}), 128'd0);
        chk("mrst.rdata", rdata, 128'd0);
        chk("mrst.outs", 128'({mem_req_valid, mem_req_rnw, proto_err}), 128'd0);
        chk("mrst.addr", 128'(mem_req_addr), 128'd0);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.idle", 128'(busy), 128'd0);
        i_req_valid = 1'b1;
        d_req_rnw = 1'b1;
        d_req_addr = D_ADDR;
        d_req_valid = 1'b1;
        serve_read("mrst_tie", TIE_I ? I_ADDR : D_ADDR, TIE_I, 0, 1'b1, 128'h0E00, n);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        chk("mrst.proto_clear", 128'(proto_err), 128'd0);

        // stray request accept while idle
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("stray_acc.proto", 128'(proto_err), 128'd1);
        chk("stray_acc.busy", 128'(busy), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
